// File: rtl/instr_seq_ctrl_if.sv
// instr_seq_ctrl_if: bundle between the sequencer, program memory, decoder and execute stage.
interface instr_seq_ctrl_if #(parameter int ADDR_W = 8);
  logic start;
  logic imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] dec_instr;
  logic dec_en;
  logic exec_done;
  logic [ADDR_W-1:0] pc;
  logic busy;
  logic halted;
  logic error;
  modport master(
    input start, imem_data, exec_done,
    output imem_rd, imem_addr, dec_instr, dec_en, pc, busy, halted, error
  );
  modport slave(
    output start, imem_data, exec_done,
    input imem_rd, imem_addr, dec_instr, dec_en, pc, busy, halted, error
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: fetch/decode sequencer with local jump/halt; EXEC_TIMEOUT_EN adds an execute watchdog.
module instr_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int EXEC_TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  instr_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, DECODE, EXEC, HALT} state_t;
  state_t r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0] r_ir;
  logic r_rd, r_en, r_busy, r_halted;
  logic [3:0] w_op;
  assign w_op = bus.imem_data[15:12];
`ifdef EXEC_TIMEOUT_EN
  localparam int CW = ($clog2(EXEC_TIMEOUT + 1) > 8) ? $clog2(EXEC_TIMEOUT + 1) : 8;
  logic [CW-1:0] r_cnt;
  logic r_err;
  assign bus.error = r_err;
`else
  assign bus.error = 1'b0;
`endif
  assign bus.imem_rd = r_rd;
  assign bus.imem_addr = r_pc;
  assign bus.pc = r_pc;
  assign bus.dec_instr = r_ir;
  assign bus.dec_en = r_en;
  assign bus.busy = r_busy;
  assign bus.halted = r_halted;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_ir <= '0;
      r_rd <= 1'b0;
      r_en <= 1'b0;
      r_busy <= 1'b0;
      r_halted <= 1'b0;
`ifdef EXEC_TIMEOUT_EN
      r_cnt <= '0;
      r_err <= 1'b0;
`endif
    end else begin
      r_rd <= 1'b0;
      r_en <= 1'b0;
      case (r_state)
        IDLE, HALT: if (bus.start) begin
          r_state <= FETCH;
          r_pc <= '0;
          r_rd <= 1'b1;
          r_busy <= 1'b1;
          r_halted <= 1'b0;
`ifdef EXEC_TIMEOUT_EN
          r_err <= 1'b0;
`endif
        end
        FETCH: r_state <= WAIT_MEM;
        WAIT_MEM: begin
          r_ir <= bus.imem_data;
          if (w_op == 4'hF) begin
            r_state <= HALT;
            r_busy <= 1'b0;
            r_halted <= 1'b1;
          end else if (w_op == 4'hE) begin
            r_pc <= bus.imem_data[ADDR_W-1:0];
            r_state <= FETCH;
            r_rd <= 1'b1;
          end else begin
            r_state <= DECODE;
            r_en <= 1'b1;
          end
        end
        DECODE: begin
`ifdef EXEC_TIMEOUT_EN
          r_cnt <= '0;
`endif
          if (r_ir[15:12] == 4'h0) begin
            r_pc <= r_pc + 1'b1;
            r_state <= FETCH;
            r_rd <= 1'b1;
          end else r_state <= EXEC;
        end
        EXEC: if (bus.exec_done) begin
          r_pc <= r_pc + 1'b1;
          r_state <= FETCH;
          r_rd <= 1'b1;
        end
`ifdef EXEC_TIMEOUT_EN
        // r_cnt holds EXEC cycles already elapsed, so this is the last allowed cycle
        else if (r_cnt == CW'(EXEC_TIMEOUT - 1)) begin
          r_state <= HALT;
          r_busy <= 1'b0;
          r_halted <= 1'b1;
          r_err <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: directed scenarios against a synchronous program-memory model.
module tb_instr_seq_ctrl;
  logic clk, reset;
  int checks = 0, errors = 0, n_en = 0;
  logic [15:0] mem [256];
  instr_seq_ctrl_if #(.ADDR_W(8)) bus();
  instr_seq_ctrl #(.ADDR_W(8), .EXEC_TIMEOUT(4)) dut(.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];
  always @(posedge clk) if (bus.dec_en) n_en <= n_en + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", bus.halted); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b exp 0", bus.error); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h exp 00", bus.pc); end
    checks++; if (bus.dec_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h exp 0000", bus.dec_instr); end
    checks++; if (bus.dec_en !== 1'b0 || bus.imem_rd !== 1'b0) begin errors++; $display("FAIL reset_strobes: got en=%b rd=%b exp 0 0", bus.dec_en, bus.imem_rd); end
  endtask

  task automatic test_basic();
    int base;
    clear_mem();
    mem[0] = 16'h1041;
    base = n_en;
    do_start();
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL basic_fetch0: got rd=%b addr=%h exp 1 00", bus.imem_rd, bus.imem_addr); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", bus.busy); end
    step();
    checks++; if (bus.dec_en !== 1'b0) begin errors++; $display("FAIL basic_early_en: got %b exp 0", bus.dec_en); end
    step();
    checks++; if (bus.dec_en !== 1'b1 || bus.dec_instr !== 16'h1041) begin errors++; $display("FAIL basic_decode: got en=%b instr=%h exp 1 1041", bus.dec_en, bus.dec_instr); end
    step();
    checks++; if (bus.dec_en !== 1'b0) begin errors++; $display("FAIL basic_en_width: got %b exp 0", bus.dec_en); end
    step();
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h01) begin errors++; $display("FAIL basic_fetch1: got rd=%b addr=%h exp 1 01", bus.imem_rd, bus.imem_addr); end
    step();
    step();
    checks++; if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== 8'h01) begin errors++; $display("FAIL basic_halt: got halted=%b busy=%b pc=%h exp 1 0 01", bus.halted, bus.busy, bus.pc); end
    checks++; if (n_en - base !== 1) begin errors++; $display("FAIL basic_en_count: got %0d exp 1", n_en - base); end
  endtask

  task automatic test_nop();
    int base, cnt, first, last;
    clear_mem();
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h0000;
    base = n_en; cnt = 0; first = -1; last = 0;
    do_start();
    for (int c = 1; c <= 12; c++) begin
      if (bus.dec_en === 1'b1) begin
        if (cnt == 0) first = c;
        else begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL nop_spacing: got %0d exp 3", c - last); end
        end
        last = c;
        cnt++;
      end
      step();
    end
    checks++; if (first !== 3) begin errors++; $display("FAIL nop_first_en: got %0d exp 3", first); end
    checks++; if (cnt !== 3 || n_en - base !== 3) begin errors++; $display("FAIL nop_en_count: got %0d/%0d exp 3", cnt, n_en - base); end
    checks++; if (bus.halted !== 1'b1 || bus.pc !== 8'h03 || bus.error !== 1'b0) begin errors++; $display("FAIL nop_halt: got halted=%b pc=%h err=%b exp 1 03 0", bus.halted, bus.pc, bus.error); end
  endtask

  task automatic test_jump();
    int base;
    clear_mem();
    mem[0] = 16'hE005; mem[5] = 16'h2ABC;
    base = n_en;
    do_start();
    step();
    step();
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h05) begin errors++; $display("FAIL jump_fetch: got rd=%b addr=%h exp 1 05", bus.imem_rd, bus.imem_addr); end
    checks++; if (bus.dec_en !== 1'b0 || bus.dec_instr !== 16'hE005) begin errors++; $display("FAIL jump_ir: got en=%b instr=%h exp 0 e005", bus.dec_en, bus.dec_instr); end
    step();
    step();
    checks++; if (bus.dec_en !== 1'b1 || bus.dec_instr !== 16'h2ABC) begin errors++; $display("FAIL jump_decode: got en=%b instr=%h exp 1 2abc", bus.dec_en, bus.dec_instr); end
    step();
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h06) begin errors++; $display("FAIL jump_next: got rd=%b addr=%h exp 1 06", bus.imem_rd, bus.imem_addr); end
    step();
    step();
    checks++; if (bus.halted !== 1'b1 || n_en - base !== 1) begin errors++; $display("FAIL jump_halt: got halted=%b en_count=%0d exp 1 1", bus.halted, n_en - base); end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 16'hE0FF; mem[255] = 16'h3001;
    do_start();
    step();
    step();
    checks++; if (bus.imem_addr !== 8'hFF || bus.imem_rd !== 1'b1) begin errors++; $display("FAIL wrap_fetch: got rd=%b addr=%h exp 1 ff", bus.imem_rd, bus.imem_addr); end
    step();
    step();
    checks++; if (bus.dec_en !== 1'b1 || bus.dec_instr !== 16'h3001) begin errors++; $display("FAIL wrap_decode: got en=%b instr=%h exp 1 3001", bus.dec_en, bus.dec_instr); end
    step();
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h00 || bus.pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got rd=%b addr=%h pc=%h exp 1 00 00", bus.imem_rd, bus.imem_addr, bus.pc); end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = 16'h4123;
    do_start();
    step();
    step();
    step();
    checks++; if (bus.busy !== 1'b1 || bus.dec_instr !== 16'h4123) begin errors++; $display("FAIL rmid_exec: got busy=%b instr=%h exp 1 4123", bus.busy, bus.dec_instr); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.pc !== 8'h00 || bus.dec_instr !== 16'h0000 || bus.halted !== 1'b0) begin errors++; $display("FAIL rmid_state: got busy=%b pc=%h instr=%h halted=%b exp 0 00 0000 0", bus.busy, bus.pc, bus.dec_instr, bus.halted); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.imem_rd !== 1'b0) begin errors++; $display("FAIL rmid_idle: got busy=%b rd=%b exp 0 0", bus.busy, bus.imem_rd); end
  endtask

  task automatic test_start_busy();
    clear_mem();
    mem[0] = 16'h5000;
    do_start();
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.dec_en !== 1'b1 || bus.dec_instr !== 16'h5000) begin errors++; $display("FAIL sbusy_decode: got en=%b instr=%h exp 1 5000", bus.dec_en, bus.dec_instr); end
    step();
    bus.start = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b1 || bus.imem_rd !== 1'b0 || bus.pc !== 8'h00) begin errors++; $display("FAIL sbusy_exec: got busy=%b rd=%b pc=%h exp 1 0 00", bus.busy, bus.imem_rd, bus.pc); end
    step();
    checks++; if (bus.imem_rd !== 1'b0) begin errors++; $display("FAIL sbusy_norestart: got %b exp 0", bus.imem_rd); end
    bus.start = 1'b0;
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h01) begin errors++; $display("FAIL sbusy_next: got rd=%b addr=%h exp 1 01", bus.imem_rd, bus.imem_addr); end
    step();
    step();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL sbusy_halt: got %b exp 1", bus.halted); end
  endtask

  task automatic test_back_to_back();
    int cnt, first, last;
    logic [15:0] exp_instr;
    clear_mem();
    mem[0] = 16'h7001; mem[1] = 16'h7002; mem[2] = 16'h7003;
    cnt = 0; first = -1; last = 0;
    bus.exec_done = 1'b1;
    do_start();
    for (int c = 1; c <= 15; c++) begin
      if (bus.dec_en === 1'b1) begin
        exp_instr = 16'h7001 + 16'(cnt);
        checks++; if (bus.dec_instr !== exp_instr) begin errors++; $display("FAIL b2b_instr: got %h exp %h", bus.dec_instr, exp_instr); end
        if (cnt == 0) first = c;
        else begin
          checks++; if (c - last !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d exp 4", c - last); end
        end
        last = c;
        cnt++;
      end
      step();
    end
    bus.exec_done = 1'b0;
    checks++; if (first !== 3 || cnt !== 3) begin errors++; $display("FAIL b2b_count: got first=%0d cnt=%0d exp 3 3", first, cnt); end
    checks++; if (bus.halted !== 1'b1 || bus.pc !== 8'h03) begin errors++; $display("FAIL b2b_halt: got halted=%b pc=%h exp 1 03", bus.halted, bus.pc); end
  endtask

`ifdef EXEC_TIMEOUT_EN
  task automatic test_timeout();
    clear_mem();
    mem[0] = 16'h8000;
    do_start();
    for (int i = 0; i < 6; i++) step();
    checks++; if (bus.halted !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL tmo_early: got halted=%b busy=%b exp 0 1", bus.halted, bus.busy); end
    step();
    checks++; if (bus.halted !== 1'b1 || bus.error !== 1'b1 || bus.pc !== 8'h00) begin errors++; $display("FAIL tmo_halt: got halted=%b err=%b pc=%h exp 1 1 00", bus.halted, bus.error, bus.pc); end
    mem[1] = 16'hF000;
    do_start();
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b exp 0", bus.error); end
    for (int i = 0; i < 6; i++) step();
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h01 || bus.error !== 1'b0) begin errors++; $display("FAIL tmo_done_wins: got rd=%b addr=%h err=%b exp 1 01 0", bus.imem_rd, bus.imem_addr, bus.error); end
    step();
    step();
    checks++; if (bus.halted !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("FAIL tmo_clean_halt: got halted=%b err=%b exp 1 0", bus.halted, bus.error); end
  endtask
`else
  task automatic test_no_timeout();
    clear_mem();
    mem[0] = 16'h8000;
    do_start();
    for (int i = 0; i < 20; i++) step();
    checks++; if (bus.busy !== 1'b1 || bus.halted !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL wait_forever: got busy=%b halted=%b err=%b exp 1 0 0", bus.busy, bus.halted, bus.error); end
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h01) begin errors++; $display("FAIL wait_release: got rd=%b addr=%h exp 1 01", bus.imem_rd, bus.imem_addr); end
    step();
    step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.exec_done = 1'b0;
    clear_mem();
    test_reset();
    test_basic();
    test_nop();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
`ifdef EXEC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
- Instruction sequencer that fetches 16-bit words from a synchronous instruction memory and presents them to the ID100 decode register.
- Pulses the decoder load enable once per instruction, then waits for the execute stage to finish before fetching the next word.
- Handles jump and halt opcodes locally, so these never reach the decoder.
- Sits between program memory and ID100; one instance per core.

Parameters:
- ADDR_W, 8, instruction-memory address width; PC wraps modulo 2^ADDR_W.
- EXEC_TIMEOUT, 255, maximum cycles to wait for exec_done (used only with EXEC_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin execution from address 0; honoured only in IDLE or HALT.
- imem_rd  out  1  instruction-memory read strobe.
- imem_addr  out  ADDR_W  read address, equal to pc.
- imem_data  in  16  read data, valid the cycle after imem_rd.
- dec_instr  out  16  instruction word driven to the decoder instr input.
- dec_en  out  1  one-cycle load pulse to the decoder en input.
- exec_done  in  1  execute stage finished the current instruction.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- error  out  1  high in HALT if it was entered by timeout.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is synchronous and active-high on port reset.
  - Reset (including mid-operation) forces state IDLE, pc=0, dec_instr=0, and dec_en/imem_rd/busy/halted/error=0.
- States:
  - IDLE: start=1 -> FETCH, pc<=0.
  - FETCH: imem_rd=1, imem_addr=pc -> WAIT_MEM.
  - WAIT_MEM: capture imem_data into the ir register; opcode=imem_data[15:12].
    - 4'hF (HALT) -> HALT.
    - 4'hE (JUMP) -> pc<=imem_data[ADDR_W-1:0], then FETCH.
    - Otherwise -> DECODE.
  - DECODE: dec_en=1 for exactly this cycle; dec_instr=ir.
    - opcode 4'h0 (NOP) -> pc<=pc+1, then FETCH.
    - Otherwise -> EXEC.
  - EXEC: wait for exec_done=1, then pc<=pc+1 and go to FETCH. exec_done is sampled only in EXEC; a pulse during DECODE is ignored.
  - HALT: halted=1, pc holds. start=1 -> FETCH with pc<=0, halted/error cleared.
- dec_instr is driven from ir and changes only on capture in WAIT_MEM. The decoder sees the new value in the DECODE cycle and it holds until the next capture. HALT/JUMP words update ir but never assert dec_en.
- Latency: start sampled in cycle 0 -> imem_rd in cycle 1 -> dec_en in cycle 3. exec_done in cycle N -> imem_rd in cycle N+1.
- pc increments modulo 2^ADDR_W: pc=2^ADDR_W-1 increments to 0.
- start is ignored while busy=1.
- Boundary cases:
  - A jump target equal to pc is legal (self-loop).
  - exec_done held high continuously gives a 4-cycle instruction rate.

Optional Feature:
- Macro EXEC_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on DECODE entry and counts cycles in EXEC.
  - If it reaches EXEC_TIMEOUT without exec_done -> HALT with error=1; pc points at the stalled instruction.
  - If exec_done arrives on the same cycle as the timeout, exec_done wins.
- Not defined: EXEC waits indefinitely and error is tied to 0.

Test Plan:
- Reset then start: mem[0]=16'h1041, exec_done after 2 cycles in EXEC -> imem_rd at cycle 1 with addr 0; dec_en at cycle 3 with dec_instr=16'h1041; next imem_rd with addr 1.
- NOP stream: mem[0..2]=16'h0000, mem[3]=16'hF000 -> three dec_en pulses spaced 3 cycles apart, then halted=1, pc=3, no dec_en for the HALT word.
- Jump: mem[0]=16'hE005, mem[5]=16'h2ABC -> no dec_en for 16'hE005; fetch addr 5; dec_en with 16'h2ABC.
- Wrap: ADDR_W=8, jump to 8'hFF containing 16'h3001, exec_done -> next imem_addr=8'h00.
- Reset asserted in EXEC -> next cycle state IDLE, pc=0, busy=0, dec_instr=0. Start during busy is ignored; start in HALT restarts at addr 0.
- With EXEC_TIMEOUT_EN and EXEC_TIMEOUT=4: exec_done never arrives -> halted=1, error=1 after 4 EXEC cycles. With exec_done on the 4th cycle -> error=0 and fetch continues.
